// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the two requester byte streams and the shared uart_tx pins.
// master = requesters plus uart_tx side; slave = the arbiter itself.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;

    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    logic [1:0] grant;
    logic       pkt_abort;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_busy,
        input  req0_ready, req1_ready,
        input  tx_start, tx_data, grant, pkt_abort
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_busy,
        output req0_ready, req1_ready,
        output tx_start, tx_data, grant, pkt_abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx between two byte streams.
// A grant lasts from a packet's first byte to its last; a hold timeout reclaims a stalled link.
module uart_tx_arbiter #(
    parameter int HOLD_TIMEOUT = 1250000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int CNT_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_TIMEOUT > 0) ? CNT_W'(HOLD_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        WAIT,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       tx_data_q;
    logic [7:0]       tx_data_nxt;
    logic             pkt_last_q;
    logic             pkt_last_nxt;
    logic [1:0]       grant_q;
    logic [1:0]       grant_nxt;
    logic             last_srv_q;
    logic             last_srv_nxt;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             tx_start_q;
    logic             tx_start_nxt;
    logic             pkt_abort_q;
    logic             pkt_abort_nxt;
    logic             ready0;
    logic             ready1;
    logic             take;
    logic             sel1;
    logic             win1;
    logic             owner_valid;

    // Requester 1 wins only when it is alone or requester 0 was served last.
    assign win1        = bus.req1_valid && (!bus.req0_valid || !last_srv_q);
    assign owner_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data_q   <= 8'h00;
            pkt_last_q  <= 1'b0;
            grant_q     <= 2'b00;
            last_srv_q  <= 1'b1;
            hold_cnt_q  <= '0;
            tx_start_q  <= 1'b0;
            pkt_abort_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            tx_data_q   <= tx_data_nxt;
            pkt_last_q  <= pkt_last_nxt;
            grant_q     <= grant_nxt;
            last_srv_q  <= last_srv_nxt;
            hold_cnt_q  <= hold_cnt_nxt;
            tx_start_q  <= tx_start_nxt;
            pkt_abort_q <= pkt_abort_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tx_data_nxt   = tx_data_q;
        pkt_last_nxt  = pkt_last_q;
        grant_nxt     = grant_q;
        last_srv_nxt  = last_srv_q;
        hold_cnt_nxt  = hold_cnt_q;
        tx_start_nxt  = 1'b0;
        pkt_abort_nxt = 1'b0;
        ready0        = 1'b0;
        ready1        = 1'b0;
        take          = 1'b0;
        sel1          = 1'b0;

        case (state)
            IDLE: begin
                ready0 = bus.req0_valid && !win1;
                ready1 = win1;
                if (bus.req0_valid || bus.req1_valid) begin
                    take = 1'b1;
                    sel1 = win1;
                end
            end

            START: state_nxt = GAP;

            // tx_busy may still be low here because uart_tx flags busy a cycle late.
            GAP: state_nxt = WAIT;

            WAIT: begin
                if (!bus.tx_busy) begin
                    if (pkt_last_q) begin
                        last_srv_nxt = grant_q[1];
                        grant_nxt    = 2'b00;
                        state_nxt    = IDLE;
                    end else begin
                        hold_cnt_nxt = '0;
                        state_nxt    = HOLD;
                    end
                end
            end

            HOLD: begin
                ready0 = !grant_q[1];
                ready1 = grant_q[1];
                if (owner_valid) begin
                    take = 1'b1;
                    sel1 = grant_q[1];
                end else if (HOLD_TIMEOUT != 0 && hold_cnt_q == CNT_LAST) begin
                    pkt_abort_nxt = 1'b1;
                    last_srv_nxt  = grant_q[1];
                    grant_nxt     = 2'b00;
                    state_nxt     = IDLE;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_nxt = hold_cnt_q + 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase

        if (take) begin
            tx_data_nxt  = sel1 ? bus.req1_data : bus.req0_data;
            pkt_last_nxt = sel1 ? bus.req1_last : bus.req0_last;
            grant_nxt    = sel1 ? 2'b10 : 2'b01;
            tx_start_nxt = 1'b1;
            state_nxt    = START;
        end
    end

    // Ready is forced low while reset is held, even though the FSM sits in IDLE.
    assign bus.req0_ready = ready0 && rst_n;
    assign bus.req1_ready = ready1 && rst_n;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.grant      = grant_q;
    assign bus.pkt_abort  = pkt_abort_q;

endmodule
